rs_select: RTL and testbench
============================

Name: rs_select

Overview:
- Wakeup/select scheduler for one reservation station (RS): 8 entries, 2 dispatch slots in, 2 issue ports out.
- Tracks per-entry valid bits, source-operand ready bits and relative age; snoops CDB broadcasts to wake operands.
- Each cycle grants up to two ready entries, oldest first, to available functional-unit (FU) ports.
- Sits between rename/dispatch and the FU operand-read stage; the RS payload RAM is indexed by alloc_idx on write and issue_idx on read.

Parameters:
- N, 8, RS entries.
- IW, 3, entry index width (log2 N).
- PRW, 6, physical register tag width.
- NCDB, 2, CDB broadcast ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- recovery_en  in  1  flush: invalidate all entries
- alloc_en  in  [1:0]  dispatch slot s writes an entry this cycle
- alloc_idx  in  [1:0][IW-1:0]  free entry index per slot; never a valid entry; slots distinct when both enabled
- alloc_rs1  in  [1:0][PRW-1:0]  source 1 physical tag
- alloc_rs2  in  [1:0][PRW-1:0]  source 2 physical tag
- alloc_rdy1  in  [1:0]  source 1 already ready at dispatch
- alloc_rdy2  in  [1:0]  source 2 already ready at dispatch
- cdb_en  in  [NCDB-1:0]  broadcast valid
- cdb_tag  in  [NCDB-1:0][PRW-1:0]  broadcast tag
- fu_rdy  in  [1:0]  FU port p accepts an issue this cycle
- issue_en  out  [1:0]  port p issues this cycle
- issue_idx  out  [1:0][IW-1:0]  entry issued on port p
- valid_vec  out  [N-1:0]  entry occupancy, for the free-list allocator
- rs_empty  out  1  no valid entries

Behaviour:
- State per entry: valid, rdy1, rdy2, tag1, tag2, plus an NxN age matrix (age[i][j]=1: entry i older than entry j).
- Reset and recovery:
  - rst or recovery_en clears all valid bits on the next edge.
  - issue_en=0 in the cycle rst or recovery_en is high; issue_idx=0.
  - valid_vec=0 and rs_empty=1 after reset.
  - recovery_en overrides alloc and wakeup in the same cycle.
- Allocation, slot s with alloc_en[s]=1:
  - At the next edge: valid=1, tags written, rdy1/rdy2 loaded from alloc_rdy* OR a same-cycle CDB tag match.
  - Age: the new entry is younger than every entry valid after that edge. Row age[new][*]=0; column age[j][new]=1 for every other valid j.
  - Both slots in one cycle: slot 0 is older than slot 1.
- Wakeup:
  - Any cdb_en[k] with cdb_tag[k]==tagX of a valid entry sets rdyX at the next edge.
  - Ready bits never clear while the entry is valid.
  - Wakeup-to-eligible latency is 1 cycle: select uses registered ready bits only.
- Select, combinational from registered state:
  - cand[i] = valid & rdy1 & rdy2.
  - first = cand with no older cand; second = oldest cand excluding first.
  - first goes to the lowest-numbered port with fu_rdy=1; second goes to the remaining ready port.
  - Fewer ready ports or candidates: the excess gets no grant and its issue_en=0.
- Deallocation: an issued entry's valid clears at the next edge and is not reselected. Its age row/column are don't-care until reallocated.
- Simultaneous events:
  - Alloc into index i in the same cycle that entry i issues cannot occur, because an issued entry is still valid.
  - Wakeup for an entry being issued is ignored.
- valid_vec and rs_empty reflect registered valid.

Test Plan:
- Reset, then alloc idx3 with both sources ready, fu_rdy=2'b11 -> next cycle issue_en=2'b01, issue_idx[0]=3; the following cycle valid_vec=0, rs_empty=1.
- Alloc idx5 (tags 10,11, not ready); CDB tag 10 at cycle t, tag 11 at t+1 -> issue_en[0] first rises at t+2 with idx 5.
- Alloc idx6 then idx1 one cycle later, both ready, fu_rdy=2'b01 -> idx6 issues first on port 0, idx1 issues the next cycle.
- Same-cycle dual alloc, slot0=idx2 and slot1=idx0, both ready, fu_rdy=2'b11 -> port0 gets idx2, port1 gets idx0 in the same cycle.
- Three ready entries, fu_rdy=2'b10 -> only port1 issues, the oldest entry.
- Four valid entries, recovery_en pulsed together with alloc_en=2'b11 -> next cycle valid_vec=0, no issue.

Source files
------------

// File: rtl/rs_select_if.sv
// Dispatch/CDB/FU-facing signal bundle for the rs_select wakeup/select scheduler.
interface rs_select_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned IW   = 3,
  parameter int unsigned PRW  = 6,
  parameter int unsigned NCDB = 2
);
  logic                      recovery_en;
  logic [1:0]                alloc_en;
  logic [1:0][IW-1:0]        alloc_idx;
  logic [1:0][PRW-1:0]       alloc_rs1;
  logic [1:0][PRW-1:0]       alloc_rs2;
  logic [1:0]                alloc_rdy1;
  logic [1:0]                alloc_rdy2;
  logic [NCDB-1:0]           cdb_en;
  logic [NCDB-1:0][PRW-1:0]  cdb_tag;
  logic [1:0]                fu_rdy;
  logic [1:0]                issue_en;
  logic [1:0][IW-1:0]        issue_idx;
  logic [N-1:0]              valid_vec;
  logic                      rs_empty;

  modport master (
    output recovery_en, alloc_en, alloc_idx, alloc_rs1, alloc_rs2, alloc_rdy1, alloc_rdy2,
           cdb_en, cdb_tag, fu_rdy,
    input  issue_en, issue_idx, valid_vec, rs_empty
  );

  modport slave (
    input  recovery_en, alloc_en, alloc_idx, alloc_rs1, alloc_rs2, alloc_rdy1, alloc_rdy2,
           cdb_en, cdb_tag, fu_rdy,
    output issue_en, issue_idx, valid_vec, rs_empty
  );
endinterface

// File: rtl/rs_select.sv
// Reservation-station wakeup/select: tracks operand readiness and age, and grants
// up to two ready entries per cycle, oldest first, to the available FU ports.
module rs_select #(
  parameter int unsigned N    = 8,
  parameter int unsigned IW   = 3,
  parameter int unsigned PRW  = 6,
  parameter int unsigned NCDB = 2
) (
  input  logic       clk,
  input  logic       rst,
  rs_select_if.slave rs
);

  logic [N-1:0]          r_valid;
  logic [N-1:0]          r_rdy1;
  logic [N-1:0]          r_rdy2;
  logic [N-1:0][PRW-1:0] r_tag1;
  logic [N-1:0][PRW-1:0] r_tag2;
  logic [N-1:0][N-1:0]   r_age;

  logic [N-1:0]   w_cand;
  logic [N-1:0]   w_cand2;
  logic [N-1:0]   w_first;
  logic [N-1:0]   w_second;
  logic [IW-1:0]  w_first_idx;
  logic [IW-1:0]  w_second_idx;
  logic [1:0]     w_issue_en;
  logic [1:0][IW-1:0] w_issue_idx;
  logic [N-1:0]   w_issued;
  logic [N-1:0]   w_alloc_oh;
  logic [N-1:0]   w_wake1;
  logic [N-1:0]   w_wake2;
  logic [1:0]     w_amatch1;
  logic [1:0]     w_amatch2;
  logic           w_flush;

  assign w_flush = rst | rs.recovery_en;

  // Oldest candidate, then oldest of the rest, from the age matrix.
  always_comb begin
    w_cand  = r_valid & r_rdy1 & r_rdy2;
    w_first = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_first[i] = w_cand[i];
      for (int j = 0; j < int'(N); j++)
        if (j != i && w_cand[j] && r_age[j][i]) w_first[i] = 1'b0;
    end
    w_cand2  = w_cand & ~w_first;
    w_second = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_second[i] = w_cand2[i];
      for (int j = 0; j < int'(N); j++)
        if (j != i && w_cand2[j] && r_age[j][i]) w_second[i] = 1'b0;
    end
  end

  always_comb begin
    w_first_idx  = '0;
    w_second_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_first[i])  w_first_idx  = IW'(i);
      if (w_second[i]) w_second_idx = IW'(i);
    end
  end

  // First pick takes the lowest ready port; second pick takes the other one.
  always_comb begin
    w_issue_en  = '0;
    w_issue_idx = '0;
    if (!w_flush) begin
      if (rs.fu_rdy[0]) begin
        if (|w_first) begin
          w_issue_en[0]  = 1'b1;
          w_issue_idx[0] = w_first_idx;
        end
        if (rs.fu_rdy[1] && |w_second) begin
          w_issue_en[1]  = 1'b1;
          w_issue_idx[1] = w_second_idx;
        end
      end else if (rs.fu_rdy[1] && |w_first) begin
        w_issue_en[1]  = 1'b1;
        w_issue_idx[1] = w_first_idx;
      end
    end
    w_issued = ((|w_issue_en) ? w_first : '0) | ((&w_issue_en) ? w_second : '0);
  end

  always_comb begin
    w_wake1    = '0;
    w_wake2    = '0;
    w_amatch1  = '0;
    w_amatch2  = '0;
    w_alloc_oh = '0;
    for (int k = 0; k < int'(NCDB); k++) begin
      if (rs.cdb_en[k]) begin
        for (int i = 0; i < int'(N); i++) begin
          if (rs.cdb_tag[k] == r_tag1[i]) w_wake1[i] = 1'b1;
          if (rs.cdb_tag[k] == r_tag2[i]) w_wake2[i] = 1'b1;
        end
        for (int s = 0; s < 2; s++) begin
          if (rs.cdb_tag[k] == rs.alloc_rs1[s]) w_amatch1[s] = 1'b1;
          if (rs.cdb_tag[k] == rs.alloc_rs2[s]) w_amatch2[s] = 1'b1;
        end
      end
    end
    for (int s = 0; s < 2; s++)
      if (rs.alloc_en[s]) w_alloc_oh[rs.alloc_idx[s]] = 1'b1;
  end

  // Slot 1 updates after slot 0 so a dual allocation leaves slot 0 as the older entry.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_valid <= '0;
    end else begin
      r_valid <= (r_valid & ~w_issued) | w_alloc_oh;
      r_rdy1  <= r_rdy1 | w_wake1;
      r_rdy2  <= r_rdy2 | w_wake2;
      for (int s = 0; s < 2; s++) begin
        if (rs.alloc_en[s]) begin
          r_tag1[rs.alloc_idx[s]] <= rs.alloc_rs1[s];
          r_tag2[rs.alloc_idx[s]] <= rs.alloc_rs2[s];
          r_rdy1[rs.alloc_idx[s]] <= rs.alloc_rdy1[s] | w_amatch1[s];
          r_rdy2[rs.alloc_idx[s]] <= rs.alloc_rdy2[s] | w_amatch2[s];
          r_age[rs.alloc_idx[s]]  <= '0;
          for (int j = 0; j < int'(N); j++)
            if (j != int'(rs.alloc_idx[s])) r_age[j][rs.alloc_idx[s]] <= 1'b1;
        end
      end
    end
  end

  assign rs.issue_en  = w_issue_en;
  assign rs.issue_idx = w_issue_idx;
  assign rs.valid_vec = r_valid;
  assign rs.rs_empty  = ~|r_valid;

endmodule

// File: tb/tb_rs_select.sv
// Directed bench for rs_select: reset, wakeup timing, age ordering, port steering, recovery.
module tb_rs_select;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rs_select_if #(.N(8), .IW(3), .PRW(6), .NCDB(2)) bus ();

  rs_select #(.N(8), .IW(3), .PRW(6), .NCDB(2)) dut (
    .clk (clk),
    .rst (rst),
    .rs  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.recovery_en = 1'b0;
    bus.alloc_en    = '0;
    bus.alloc_idx   = '0;
    bus.alloc_rs1   = '0;
    bus.alloc_rs2   = '0;
    bus.alloc_rdy1  = '0;
    bus.alloc_rdy2  = '0;
    bus.cdb_en      = '0;
    bus.cdb_tag     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input int s, input logic [2:0] idx, input logic [5:0] t1,
                       input logic [5:0] t2, input logic r1, input logic r2);
    bus.alloc_en[s]   = 1'b1;
    bus.alloc_idx[s]  = idx;
    bus.alloc_rs1[s]  = t1;
    bus.alloc_rs2[s]  = t2;
    bus.alloc_rdy1[s] = r1;
    bus.alloc_rdy2[s] = r2;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); bus.fu_rdy = 2'b00;
    tick(); tick();
    rst = 1'b0;
    alloc(0, 3'd3, 6'd1, 6'd2, 1'b1, 1'b1);
    tick();
    idle(); rst = 1'b1; bus.fu_rdy = 2'b11; #1;
    n_checks++;
    if (bus.issue_en !== 2'b00) begin n_fail++; $display("FAIL reset_issue_en got %b exp 00", bus.issue_en); end
    n_checks++;
    if (bus.issue_idx !== 6'd0) begin n_fail++; $display("FAIL reset_issue_idx got %h exp 0", bus.issue_idx); end
    tick();
    rst = 1'b0; #1;
    n_checks++;
    if (bus.valid_vec !== 8'h00) begin n_fail++; $display("FAIL reset_valid got %h exp 00", bus.valid_vec); end
    n_checks++;
    if (bus.rs_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", bus.rs_empty); end
  endtask

  task automatic test_basic_issue();
    bus.fu_rdy = 2'b11;
    alloc(0, 3'd3, 6'd4, 6'd5, 1'b1, 1'b1);
    tick();
    idle(); #1;
    n_checks++;
    if (bus.issue_en !== 2'b01) begin n_fail++; $display("FAIL basic_en got %b exp 01", bus.issue_en); end
    n_checks++;
    if (bus.issue_idx[0] !== 3'd3) begin n_fail++; $display("FAIL basic_idx got %0d exp 3", bus.issue_idx[0]); end
    n_checks++;
    if (bus.valid_vec !== 8'h08) begin n_fail++; $display("FAIL basic_valid got %h exp 08", bus.valid_vec); end
    tick();
    n_checks++;
    if (bus.valid_vec !== 8'h00) begin n_fail++; $display("FAIL basic_dealloc got %h exp 00", bus.valid_vec); end
    n_checks++;
    if (bus.rs_empty !== 1'b1 || bus.issue_en !== 2'b00) begin
      n_fail++; $display("FAIL basic_empty got empty=%b en=%b exp 1/00", bus.rs_empty, bus.issue_en);
    end
  endtask

  task automatic test_wakeup();
    bus.fu_rdy = 2'b11;
    alloc(0, 3'd5, 6'd10, 6'd11, 1'b0, 1'b0);
    tick();
    idle(); #1;
    n_checks++;
    if (bus.issue_en !== 2'b00) begin n_fail++; $display("FAIL wake_pre got %b exp 00", bus.issue_en); end
    bus.cdb_en = 2'b01; bus.cdb_tag[0] = 6'd10; #1;
    n_checks++;
    if (bus.issue_en !== 2'b00) begin n_fail++; $display("FAIL wake_t got %b exp 00", bus.issue_en); end
    tick();
    bus.cdb_en = 2'b10; bus.cdb_tag[0] = 6'd0; bus.cdb_tag[1] = 6'd11; #1;
    n_checks++;
    if (bus.issue_en !== 2'b00) begin n_fail++; $display("FAIL wake_t1 got %b exp 00", bus.issue_en); end
    tick();
    idle(); #1;
    n_checks++;
    if (bus.issue_en !== 2'b01 || bus.issue_idx[0] !== 3'd5) begin
      n_fail++; $display("FAIL wake_t2 got en=%b idx=%0d exp 01/5", bus.issue_en, bus.issue_idx[0]);
    end
    tick();
    // Operands woken by a CDB broadcast in the dispatch cycle itself.
    alloc(0, 3'd4, 6'd20, 6'd21, 1'b0, 1'b0);
    bus.cdb_en = 2'b11; bus.cdb_tag[0] = 6'd21; bus.cdb_tag[1] = 6'd20;
    tick();
    idle(); #1;
    n_checks++;
    if (bus.issue_en !== 2'b01 || bus.issue_idx[0] !== 3'd4) begin
      n_fail++; $display("FAIL wake_alloc got en=%b idx=%0d exp 01/4", bus.issue_en, bus.issue_idx[0]);
    end
    tick();
    n_checks++;
    if (bus.valid_vec !== 8'h00) begin n_fail++; $display("FAIL wake_done got %h exp 00", bus.valid_vec); end
  endtask

  task automatic test_age_order();
    bus.fu_rdy = 2'b00;
    alloc(0, 3'd6, 6'd1, 6'd1, 1'b1, 1'b1);
    tick();
    idle(); alloc(0, 3'd1, 6'd1, 6'd1, 1'b1, 1'b1);
    tick();
    idle(); bus.fu_rdy = 2'b01; #1;
    n_checks++;
    if (bus.issue_en !== 2'b01 || bus.issue_idx[0] !== 3'd6) begin
      n_fail++; $display("FAIL age_first got en=%b idx=%0d exp 01/6", bus.issue_en, bus.issue_idx[0]);
    end
    tick();
    n_checks++;
    if (bus.issue_en !== 2'b01 || bus.issue_idx[0] !== 3'd1) begin
      n_fail++; $display("FAIL age_second got en=%b idx=%0d exp 01/1", bus.issue_en, bus.issue_idx[0]);
    end
    tick();
    n_checks++;
    if (bus.valid_vec !== 8'h00) begin n_fail++; $display("FAIL age_done got %h exp 00", bus.valid_vec); end
  endtask

  task automatic test_back_to_back();
    bus.fu_rdy = 2'b11;
    alloc(0, 3'd2, 6'd1, 6'd1, 1'b1, 1'b1);
    alloc(1, 3'd0, 6'd1, 6'd1, 1'b1, 1'b1);
    tick();
    idle(); #1;
    n_checks++;
    if (bus.issue_en !== 2'b11) begin n_fail++; $display("FAIL dual_en got %b exp 11", bus.issue_en); end
    n_checks++;
    if (bus.issue_idx[0] !== 3'd2 || bus.issue_idx[1] !== 3'd0) begin
      n_fail++; $display("FAIL dual_idx got %0d/%0d exp 2/0", bus.issue_idx[0], bus.issue_idx[1]);
    end
    tick();
    n_checks++;
    if (bus.rs_empty !== 1'b1) begin n_fail++; $display("FAIL dual_empty got %b exp 1", bus.rs_empty); end
  endtask

  task automatic test_port1_only();
    bus.fu_rdy = 2'b00;
    alloc(0, 3'd7, 6'd1, 6'd1, 1'b1, 1'b1);
    tick();
    idle();
    alloc(0, 3'd4, 6'd1, 6'd1, 1'b1, 1'b1);
    alloc(1, 3'd0, 6'd1, 6'd1, 1'b1, 1'b1);
    tick();
    idle(); bus.fu_rdy = 2'b10; #1;
    n_checks++;
    if (bus.issue_en !== 2'b10 || bus.issue_idx[1] !== 3'd7) begin
      n_fail++; $display("FAIL p1_first got en=%b idx=%0d exp 10/7", bus.issue_en, bus.issue_idx[1]);
    end
    n_checks++;
    if (bus.issue_idx[0] !== 3'd0) begin n_fail++; $display("FAIL p1_idx0 got %0d exp 0", bus.issue_idx[0]); end
    tick();
    n_checks++;
    if (bus.issue_en !== 2'b10 || bus.issue_idx[1] !== 3'd4) begin
      n_fail++; $display("FAIL p1_second got en=%b idx=%0d exp 10/4", bus.issue_en, bus.issue_idx[1]);
    end
    tick();
    bus.fu_rdy = 2'b11; #1;
    n_checks++;
    if (bus.issue_en !== 2'b01 || bus.issue_idx[0] !== 3'd0) begin
      n_fail++; $display("FAIL p1_last got en=%b idx=%0d exp 01/0", bus.issue_en, bus.issue_idx[0]);
    end
    tick();
    n_checks++;
    if (bus.valid_vec !== 8'h00) begin n_fail++; $display("FAIL p1_done got %h exp 00", bus.valid_vec); end
  endtask

  task automatic test_recovery();
    bus.fu_rdy = 2'b00;
    alloc(0, 3'd1, 6'd1, 6'd1, 1'b1, 1'b1);
    alloc(1, 3'd2, 6'd30, 6'd1, 1'b0, 1'b1);
    tick();
    idle();
    alloc(0, 3'd3, 6'd1, 6'd1, 1'b1, 1'b1);
    alloc(1, 3'd5, 6'd31, 6'd32, 1'b0, 1'b0);
    tick();
    idle(); #1;
    n_checks++;
    if (bus.valid_vec !== 8'h2E) begin n_fail++; $display("FAIL rec_pre got %h exp 2e", bus.valid_vec); end
    bus.recovery_en = 1'b1; bus.fu_rdy = 2'b11;
    alloc(0, 3'd6, 6'd1, 6'd1, 1'b1, 1'b1);
    alloc(1, 3'd7, 6'd1, 6'd1, 1'b1, 1'b1);
    bus.cdb_en = 2'b01; bus.cdb_tag[0] = 6'd30; #1;
    n_checks++;
    if (bus.issue_en !== 2'b00 || bus.issue_idx !== 6'd0) begin
      n_fail++; $display("FAIL rec_issue got en=%b idx=%h exp 00/0", bus.issue_en, bus.issue_idx);
    end
    tick();
    idle(); #1;
    n_checks++;
    if (bus.valid_vec !== 8'h00) begin n_fail++; $display("FAIL rec_valid got %h exp 00", bus.valid_vec); end
    n_checks++;
    if (bus.rs_empty !== 1'b1 || bus.issue_en !== 2'b00) begin
      n_fail++; $display("FAIL rec_after got empty=%b en=%b exp 1/00", bus.rs_empty, bus.issue_en);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_age_order();
    test_back_to_back();
    test_port1_only();
    test_recovery();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
